// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and data/baud constants,
// used by both the transmit and receive paths.
package uart_pkg;

    localparam int unsigned UART_DATA_W       = 8;
    localparam int unsigned UART_BPS_9600_12M = 1250;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read; count tracks occupancy so
// full and empty are unambiguous. Writes while full are ignored.
module uart_tx_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CNT_W'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, 8N1 LSB first with internal baud timing.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned BPS_PARA   = UART_BPS_9600_12M,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   tx_data_valid,
    input  logic [UART_DATA_W-1:0] tx_data_in,
    output logic                   tx_ready,
    output logic                   tx_busy,
    output logic [LVL_W-1:0]       fifo_level,
    output logic                   rs232_tx
);

    localparam int unsigned BAUD_W = $clog2(BPS_PARA);

    uart_state_e            state;
    uart_state_e            state_next;
    logic [BAUD_W-1:0]      baud_cnt;
    logic                   bit_end;
    logic [2:0]             bit_cnt;
    logic [UART_DATA_W-1:0] shift;
    logic                   tx_r;
    logic                   tx_next;
    logic                   pop;
    logic                   shift_en;
    logic [UART_DATA_W-1:0] rd_data;
    logic [LVL_W-1:0]       fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
`ifdef UART_TX_PARITY_EN
    logic                   parity_r;
`endif

    uart_tx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .wr_en   (tx_data_valid),
        .wr_data (tx_data_in),
        .rd_en   (pop),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tx_ready   = !fifo_full;
    assign fifo_level = fifo_count;
    assign tx_busy    = (state != ST_IDLE) || !fifo_empty;
    assign rs232_tx   = tx_r;
    assign bit_end    = (state != ST_IDLE) && (baud_cnt == BAUD_W'(BPS_PARA - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Wrapping on bit_end also clears the count on every entry to START.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            baud_cnt <= '0;
        end else if (state == ST_IDLE || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
        end
    end

    // Line register lags the state by one cycle so the output is glitch-free.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shift   <= '0;
            bit_cnt <= '0;
            tx_r    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            tx_r <= tx_next;
            if (pop) begin
                shift   <= rd_data;
                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                parity_r <= ^rd_data;
`endif
            end else if (shift_en) begin
                shift   <= shift >> 1;
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        shift_en   = 1'b0;
        tx_next    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                tx_next = 1'b0;
                if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_next = shift[0];
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'(UART_DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_next = parity_r;
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BPS_PARA=4: frame shape, latency, back-to-back
// frames, FIFO overflow, mid-frame reset and (with UART_TX_PARITY_EN) the parity bit.
module tb_uart_tx_fifo;

    localparam int unsigned BPS   = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tx_data_valid;
    logic [7:0]       tx_data_in;
    logic             tx_ready;
    logic             tx_busy;
    logic [LVL_W-1:0] fifo_level;
    logic             rs232_tx;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_fifo #(
        .BPS_PARA   (BPS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .tx_data_valid (tx_data_valid),
        .tx_data_in    (tx_data_in),
        .tx_ready      (tx_ready),
        .tx_busy       (tx_busy),
        .fifo_level    (fifo_level),
        .rs232_tx      (rs232_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // Expected line pattern, bit 0 first: start, data LSB first, [parity], stop.
    function automatic logic [10:0] make_frame(input logic [7:0] d);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Write one byte while idle and check every line cycle of the resulting frame.
    task automatic send_and_capture(input logic [7:0] d);
        logic [10:0] f;
        f = make_frame(d);
        @(negedge clk);
        tx_data_valid = 1'b1;
        tx_data_in    = d;
        @(negedge clk);
        tx_data_valid = 1'b0;
        check($sformatf("cap%02h_level_after_wr", d), 32'(fifo_level), 32'(1));
        check($sformatf("cap%02h_busy_after_wr", d), 32'(tx_busy), 32'(1));
        check($sformatf("cap%02h_tx_n0", d), 32'(rs232_tx), 32'(1));
        @(negedge clk);
        check($sformatf("cap%02h_tx_n1", d), 32'(rs232_tx), 32'(1));
        for (int c = 0; c < int'(NBITS * BPS); c++) begin
            @(negedge clk);
            check($sformatf("cap%02h_line_c%0d", d, c), 32'(rs232_tx), 32'(f[c / BPS]));
            if (c == int'(NBITS * BPS) - 2) begin
                check($sformatf("cap%02h_busy_last", d), 32'(tx_busy), 32'(1));
            end
        end
        check($sformatf("cap%02h_busy_done", d), 32'(tx_busy), 32'(0));
    endtask

    // Decode one frame mid-bit; gap = idle negedges seen before the start bit.
    task automatic recv_byte(output logic [7:0] b, output int gap);
        int n;
        n = 0;
        b = '0;
        do begin
            @(negedge clk);
            n++;
        end while (rs232_tx !== 1'b0 && n < 200);
        gap = n - 1;
        check("rx_start_seen", 32'(rs232_tx), 32'(0));
        repeat (BPS / 2) @(negedge clk);
        check("rx_start_mid", 32'(rs232_tx), 32'(0));
        for (int j = 0; j < 8; j++) begin
            repeat (BPS) @(negedge clk);
            b[j] = rs232_tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (BPS) @(negedge clk);
        check("rx_parity", 32'(rs232_tx), 32'(^b));
`endif
        repeat (BPS) @(negedge clk);
        check("rx_stop", 32'(rs232_tx), 32'(1));
        repeat (BPS - BPS / 2 - 1) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         gap;
        int         lows;

        rst_n         = 1'b0;
        tx_data_valid = 1'b0;
        tx_data_in    = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(rs232_tx), 32'(1));
        check("rst_ready", 32'(tx_ready), 32'(1));
        check("rst_busy", 32'(tx_busy), 32'(0));
        check("rst_level", 32'(fifo_level), 32'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame: latency, bit order and hold time, busy release.
        send_and_capture(8'h55);
        repeat (5) @(negedge clk);

        // Back-to-back: second write lands as the first byte is popped.
        tx_data_valid = 1'b1;
        tx_data_in    = 8'hA3;
        @(negedge clk);
        tx_data_in    = 8'h0F;
        @(negedge clk);
        tx_data_valid = 1'b0;
        check("b2b_level_simul_wr_pop", 32'(fifo_level), 32'(1));
        recv_byte(b, gap);
        check("b2b_byte0", 32'(b), 32'(8'hA3));
        recv_byte(b, gap);
        check("b2b_byte1", 32'(b), 32'(8'h0F));
        check("b2b_gap", 32'(gap), 32'(0));
        repeat (2) @(negedge clk);
        check("b2b_busy_end", 32'(tx_busy), 32'(0));
        check("b2b_level_end", 32'(fifo_level), 32'(0));
        repeat (5) @(negedge clk);

        // Overflow: 18 distinct bytes offered, 17 accepted (1 in flight + 16 queued).
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    tx_data_valid = 1'b1;
                    tx_data_in    = 8'(8'h10 + i);
                    @(negedge clk);
                end
                tx_data_valid = 1'b0;
                check("ovf_level_full", 32'(fifo_level), 32'(16));
                check("ovf_ready_low", 32'(tx_ready), 32'(0));
            end
            begin
                logic [7:0] rb;
                int         rg;
                for (int k = 0; k < 17; k++) begin
                    recv_byte(rb, rg);
                    check($sformatf("ovf_byte%0d", k), 32'(rb), 32'(8'h10 + k));
                    if (k > 0) begin
                        check($sformatf("ovf_gap%0d", k), 32'(rg), 32'(0));
                    end
                end
            end
        join
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (rs232_tx !== 1'b1) lows++;
        end
        check("ovf_no_18th_frame", 32'(lows), 32'(0));
        check("ovf_busy_end", 32'(tx_busy), 32'(0));
        check("ovf_ready_end", 32'(tx_ready), 32'(1));

        // Reset mid-DATA of 0xFF with three bytes queued.
        tx_data_valid = 1'b1;
        tx_data_in    = 8'hFF;
        @(negedge clk);
        tx_data_in    = 8'h01;
        @(negedge clk);
        tx_data_in    = 8'h02;
        @(negedge clk);
        tx_data_in    = 8'h03;
        @(negedge clk);
        tx_data_valid = 1'b0;
        check("mrst_level_before", 32'(fifo_level), 32'(3));
        repeat (8) @(negedge clk);
        check("mrst_busy_before", 32'(tx_busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mrst_tx_async", 32'(rs232_tx), 32'(1));
        check("mrst_level_async", 32'(fifo_level), 32'(0));
        check("mrst_busy_async", 32'(tx_busy), 32'(0));
        check("mrst_ready_async", 32'(tx_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        lows  = 0;
        repeat (60) begin
            @(negedge clk);
            if (rs232_tx !== 1'b1) lows++;
        end
        check("mrst_line_quiet", 32'(lows), 32'(0));
        check("mrst_busy_after", 32'(tx_busy), 32'(0));
        send_and_capture(8'h3C);
        repeat (3) @(negedge clk);

        // Parity-sensitive bytes: 0x07 has odd weight, 0x03 even.
        send_and_capture(8'h07);
        repeat (3) @(negedge clk);
        send_and_capture(8'h03);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter that pairs with the existing receive path. It completes the TX half of the UART bus: 8N1 serial output, LSB first.
- Bytes are written over a valid/ready handshake into an internal FIFO, then serialised on rs232_tx.
- Baud timing is generated internally from BPS_PARA clock cycles per bit; no external beat generator is used.

Parameters:
BPS_PARA, 1250, clock cycles per bit (1250 gives 9600 baud at 12 MHz); legal range >= 2
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2
LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level (localparam, not overridable)

Ports:
clk_in  input  1  system clock, 12 MHz
rst_n_in  input  1  reset; asynchronous assert, active-low
tx_data_valid  input  1  tx_data_in valid; a write occurs on a rising edge when tx_data_valid && tx_ready
tx_data_in  input  8  byte to transmit
tx_ready  output  1  FIFO not full; combinational from registered count
tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty
fifo_level  output  LVL_W  number of bytes queued, excluding the byte being shifted
rs232_tx  output  1  serial line, registered, idles high

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Reset values: rs232_tx=1, tx_ready=1, tx_busy=0, fifo_level=0.
  - FIFO pointers, baud counter and bit counter clear; FSM enters IDLE.
  - Reset asserted mid-frame aborts the frame and forces the line high immediately. Queued data is discarded.
- FIFO: synchronous, single clock.
  - Write when tx_data_valid && tx_ready.
  - Writes while full are dropped silently; no state changes.
  - Pop is issued only by the FSM.
  - Simultaneous write and pop leave the count unchanged.
  - tx_ready does not anticipate a same-cycle pop, so a full FIFO rejects the write.
  - Pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.
- Baud counter:
  - Counts 0..BPS_PARA-1 while the FSM is not IDLE.
  - bit_end is asserted when count == BPS_PARA-1.
  - Counter clears when entering START.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the optional feature).
  - IDLE: rs232_tx=1. If FIFO non-empty: pop, load shift register, go to START.
  - START: rs232_tx=0 for BPS_PARA cycles. On bit_end go to DATA with bit_cnt=0.
  - DATA: rs232_tx=shift[0]. On bit_end shift right and increment bit_cnt. After bit 7, go to STOP.
  - STOP: rs232_tx=1 for BPS_PARA cycles. On bit_end: if FIFO non-empty, pop and go directly to START (zero idle gap); else go to IDLE.
- Latency: a write accepted at edge N makes rs232_tx fall at edge N+2 when the block is idle.
- Frame length: exactly 10*BPS_PARA cycles.
- rs232_tx is driven from a register to avoid glitches.
- tx_busy = (state != IDLE) || (count != 0).

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for BPS_PARA cycles.
  - Frame becomes 8E1, 11*BPS_PARA cycles.
- Undefined: no PARITY state, 8N1, no parity logic synthesised.

Decomposition:
- Shared package/include uart_pkg holds:
  - FSM state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), 3-bit width.
  - UART_DATA_W=8.
  - UART_BPS_9600_12M=1250.
  - The same package serves the receive side.
- One sub-module: uart_tx_sync_fifo, parameterised by depth and width.
  - Ports: wr_en/wr_data/rd_en/rd_data/count/full/empty.
  - FSM and baud logic stay in uart_tx_fifo.

Test Plan:
- BPS_PARA=4, write 0x55 while idle -> rs232_tx falls 2 cycles after the accepted write. Line is 0 then 1,0,1,0,1,0,1,0 (LSB first), then stop 1, each held 4 cycles. tx_busy drops after 40 cycles.
- Write 0xA3 then 0x0F back-to-back -> the second start bit begins the cycle after the first stop bit ends. Decoded bytes are 0xA3, 0x0F; no idle cycles between frames.
- Hold tx_data_valid for 18 cycles with distinct bytes while the line is busy -> fifo_level reaches 16 and tx_ready goes low. Overflow writes are dropped. Exactly 17 bytes go out in order: 1 in flight plus 16 queued.
- Assert rst_n_in mid-DATA of byte 0xFF with 3 bytes queued -> rs232_tx=1 asynchronously and fifo_level=0. After release no frame is sent until a new write.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 44 cycles at BPS_PARA=4. Send 0x03 -> parity bit 0.
- Write exactly as the FSM pops with FIFO count 1 -> count stays 1 and no data is lost or duplicated (scoreboard check).
